// File: rtl/rfile_wb_queue.sv
// Write-back queue feeding the register file write port, with newest-wins forwarding.
// Optional build macro RFILE_WBQ_COALESCE_EN merges a push into a tail entry with the same register.
module rfile_wb_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_reg,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     drain_en,
  output logic                     write_en,
  output logic [ADDR_W-1:0]        write_reg,
  output logic [DATA_W-1:0]        write_data,
  input  logic [ADDR_W-1:0]        fwd_reg_1,
  input  logic [ADDR_W-1:0]        fwd_reg_2,
  output logic                     fwd_hit_1,
  output logic                     fwd_hit_2,
  output logic [DATA_W-1:0]        fwd_data_1,
  output logic [DATA_W-1:0]        fwd_data_2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] reg_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     fwd_idx;
  logic              push;
  logic              pop;
  logic              coalesce;
  logic              alloc;

  assign in_ready = (count < CW'(DEPTH));
  assign push     = in_valid & in_ready;
  assign pop      = drain_en & (count != '0);

`ifdef RFILE_WBQ_COALESCE_EN
  logic [PW-1:0] tail;
  assign tail = wr_ptr - PW'(1);
  // A lone entry leaving this cycle cannot absorb the push; allocate instead.
  assign coalesce = push & (count != '0) & (reg_mem[tail] == in_reg)
                  & ~(pop & (count == CW'(1)));
`else
  assign coalesce = 1'b0;
`endif
  assign alloc = push & ~coalesce;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      write_en   <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
    end else begin
      if (alloc) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr     <= rd_ptr + PW'(1);
        write_reg  <= reg_mem[rd_ptr];
        write_data <= data_mem[rd_ptr];
      end
      write_en <= pop;
      count    <= count + CW'(alloc) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (alloc) begin
      reg_mem[wr_ptr]  <= in_reg;
      data_mem[wr_ptr] <= in_data;
    end
`ifdef RFILE_WBQ_COALESCE_EN
    else if (coalesce) begin
      data_mem[tail] <= in_data;
    end
`endif
  end

  // Scan oldest to youngest so later (younger) matches override earlier ones.
  always_comb begin
    fwd_hit_1  = 1'b0;
    fwd_hit_2  = 1'b0;
    fwd_data_1 = '0;
    fwd_data_2 = '0;
    fwd_idx    = '0;
    if (write_en && (write_reg == fwd_reg_1)) begin
      fwd_hit_1  = 1'b1;
      fwd_data_1 = write_data;
    end
    if (write_en && (write_reg == fwd_reg_2)) begin
      fwd_hit_2  = 1'b1;
      fwd_data_2 = write_data;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count) begin
        fwd_idx = rd_ptr + PW'(i);
        if (reg_mem[fwd_idx] == fwd_reg_1) begin
          fwd_hit_1  = 1'b1;
          fwd_data_1 = data_mem[fwd_idx];
        end
        if (reg_mem[fwd_idx] == fwd_reg_2) begin
          fwd_hit_2  = 1'b1;
          fwd_data_2 = data_mem[fwd_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_rfile_wb_queue.sv
// Bench for rfile_wb_queue: queue-based reference model compared every cycle, plus directed literal checks.
module tb_rfile_wb_queue;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ADDR_W-1:0] in_reg = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              drain_en = 1'b0;
  logic              write_en;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic [ADDR_W-1:0] fwd_reg_1 = '0;
  logic [ADDR_W-1:0] fwd_reg_2 = '0;
  logic              fwd_hit_1, fwd_hit_2;
  logic [DATA_W-1:0] fwd_data_1, fwd_data_2;
  logic [CW-1:0]     count;

  always #5 clk = ~clk;

  rfile_wb_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_reg(in_reg), .in_data(in_data), .drain_en(drain_en),
    .write_en(write_en), .write_reg(write_reg), .write_data(write_data),
    .fwd_reg_1(fwd_reg_1), .fwd_reg_2(fwd_reg_2),
    .fwd_hit_1(fwd_hit_1), .fwd_hit_2(fwd_hit_2),
    .fwd_data_1(fwd_data_1), .fwd_data_2(fwd_data_2), .count(count)
  );

  typedef struct {
    logic [ADDR_W-1:0] r;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t              mq[$];
  ent_t              wlog[$];
  logic              m_we = 1'b0;
  logic [ADDR_W-1:0] m_wr = '0;
  logic [DATA_W-1:0] m_wd = '0;
  int                checks = 0;
  int                failures = 0;
  bit                chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: FIFO as a queue, output stage as three variables.
  always @(posedge clk or negedge rst) begin
    bit   push, pop, co;
    int   n;
    ent_t e;
    if (!rst) begin
      mq.delete();
      m_we = 1'b0;
      m_wr = '0;
      m_wd = '0;
    end else begin
      n    = mq.size();
      push = in_valid && (n < DEPTH);
      pop  = drain_en && (n > 0);
      co   = 1'b0;
`ifdef RFILE_WBQ_COALESCE_EN
      if (push && n > 0 && mq[n-1].r == in_reg && !(pop && n == 1)) co = 1'b1;
`endif
      if (pop) begin
        e    = mq.pop_front();
        m_we = 1'b1;
        m_wr = e.r;
        m_wd = e.d;
      end else begin
        m_we = 1'b0;
      end
      if (push) begin
        if (co) mq[mq.size()-1].d = in_data;
        else begin
          e.r = in_reg;
          e.d = in_data;
          mq.push_back(e);
        end
      end
    end
  end

  function automatic void fwd_model(input logic [ADDR_W-1:0] r, output logic h,
                                    output logic [DATA_W-1:0] d);
    h = 1'b0;
    d = '0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].r == r) begin
        h = 1'b1;
        d = mq[i].d;
        return;
      end
    end
    if (m_we && m_wr == r) begin
      h = 1'b1;
      d = m_wd;
    end
  endfunction

  always @(negedge clk) begin
    logic              h;
    logic [DATA_W-1:0] d;
    ent_t              e;
    if (chk_en) begin
      chk("count", count, mq.size());
      chk("in_ready", in_ready, mq.size() < DEPTH);
      chk("write_en", write_en, m_we);
      chk("write_reg", write_reg, m_wr);
      chk("write_data", write_data, m_wd);
      fwd_model(fwd_reg_1, h, d);
      chk("fwd_hit_1", fwd_hit_1, h);
      chk("fwd_data_1", fwd_data_1, d);
      fwd_model(fwd_reg_2, h, d);
      chk("fwd_hit_2", fwd_hit_2, h);
      chk("fwd_data_2", fwd_data_2, d);
      if (write_en) begin
        e.r = write_reg;
        e.d = write_data;
        wlog.push_back(e);
      end
    end
  end

  task automatic cyc(input bit v, input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d,
                     input bit dr);
    @(posedge clk);
    #1;
    in_valid = v;
    in_reg   = r;
    in_data  = d;
    drain_en = dr;
  endtask

  task automatic check_log(input string nm, input int n, input logic [ADDR_W-1:0] rr[4],
                           input logic [DATA_W-1:0] dd[4]);
    chk({nm, "_nwrites"}, wlog.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < wlog.size()) begin
        chk({nm, "_reg"}, wlog[i].r, rr[i]);
        chk({nm, "_data"}, wlog[i].d, dd[i]);
      end
    end
  endtask

  initial begin
    logic [ADDR_W-1:0] rr[4];
    logic [DATA_W-1:0] dd[4];

    // 1: reset
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_write_en", write_en, 0);
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_fwd_hit_1", fwd_hit_1, 0);
    chk("rst_fwd_hit_2", fwd_hit_2, 0);
    chk_en = 1'b1;

    // 2: stream with drain enabled
    wlog.delete();
    cyc(1, 5'd0, 32'h2a, 1);
    cyc(1, 5'd1, 32'h37, 1);
    cyc(1, 5'd2, 32'h8b, 1);
    cyc(1, 5'd3, 32'hfd, 1);
    repeat (4) cyc(0, 5'd0, 32'h0, 1);
    @(negedge clk);
    rr = '{5'd0, 5'd1, 5'd2, 5'd3};
    dd = '{32'h2a, 32'h37, 32'h8b, 32'hfd};
    check_log("t2", 4, rr, dd);

    // 3: fill, overflow push ignored, drain in order
    cyc(1, 5'd10, 32'h100, 0);
    cyc(1, 5'd11, 32'h101, 0);
    cyc(1, 5'd12, 32'h102, 0);
    cyc(1, 5'd13, 32'h103, 0);
    cyc(1, 5'd14, 32'h104, 0);
    cyc(0, 5'd0, 32'h0, 0);
    @(negedge clk);
    chk("t3_count_full", count, 4);
    chk("t3_in_ready_full", in_ready, 0);
    wlog.delete();
    repeat (6) cyc(0, 5'd0, 32'h0, 1);
    @(negedge clk);
    rr = '{5'd10, 5'd11, 5'd12, 5'd13};
    dd = '{32'h100, 32'h101, 32'h102, 32'h103};
    check_log("t3", 4, rr, dd);

    // 4: newest-wins forwarding
    cyc(1, 5'd2, 32'h11, 0);
    cyc(1, 5'd2, 32'h22, 0);
    cyc(0, 5'd0, 32'h0, 0);
    fwd_reg_1 = 5'd2;
    fwd_reg_2 = 5'd5;
    @(negedge clk);
    chk("t4_fwd_hit_1", fwd_hit_1, 1);
    chk("t4_fwd_data_1", fwd_data_1, 32'h22);
    chk("t4_fwd_hit_2", fwd_hit_2, 0);
    chk("t4_fwd_data_2", fwd_data_2, 0);
    repeat (4) cyc(0, 5'd0, 32'h0, 1);

    // 5: asynchronous reset mid-drain
    cyc(1, 5'd20, 32'h200, 0);
    cyc(1, 5'd21, 32'h201, 0);
    cyc(1, 5'd22, 32'h202, 0);
    cyc(0, 5'd0, 32'h0, 1);
    @(posedge clk);
    #1;
    chk("t5_write_en_before", write_en, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("t5_write_en_async", write_en, 0);
    chk("t5_count_async", count, 0);
    @(negedge clk);
    rst = 1'b1;
    wlog.delete();
    repeat (4) cyc(0, 5'd0, 32'h0, 1);
    @(negedge clk);
    chk("t5_writes_after", wlog.size(), 0);

    // 6: same register pushed back to back
    cyc(1, 5'd7, 32'haa, 0);
    cyc(1, 5'd7, 32'hbb, 0);
    cyc(0, 5'd0, 32'h0, 0);
    @(negedge clk);
    wlog.delete();
    repeat (4) cyc(0, 5'd0, 32'h0, 1);
    @(negedge clk);
`ifdef RFILE_WBQ_COALESCE_EN
    rr = '{5'd7, 5'd0, 5'd0, 5'd0};
    dd = '{32'hbb, 32'h0, 32'h0, 32'h0};
    check_log("t6", 1, rr, dd);
`else
    rr = '{5'd7, 5'd7, 5'd0, 5'd0};
    dd = '{32'haa, 32'hbb, 32'h0, 32'h0};
    check_log("t6", 2, rr, dd);
`endif

    // Random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      cyc($urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom,
          $urandom_range(0, 99) < 50);
      fwd_reg_1 = 5'($urandom_range(0, 7));
      fwd_reg_2 = 5'($urandom_range(0, 7));
    end
    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
